// File: rtl/registered_combiner_if.sv
// +--------------------------------------------------------------------------+
// | registered_combiner_if : two upstream lanes and one combined downstream  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface registered_combiner_if #(
   parameter int WIDTH0 = 4,
   parameter int WIDTH1 = 4
);
   logic                     iValid_AM0;
   logic                     oReady_AM0;
   logic [WIDTH0-1:0]        iData_AM0;
   logic                     iValid_AM1;
   logic                     oReady_AM1;
   logic [WIDTH1-1:0]        iData_AM1;
   logic                     oValid_BM;
   logic                     iReady_BM;
   logic [WIDTH0+WIDTH1-1:0] oData_BM;

   modport slave (
      input  iValid_AM0, iData_AM0, iValid_AM1, iData_AM1, iReady_BM,
      output oReady_AM0, oReady_AM1, oValid_BM, oData_BM
   );

   modport master (
      output iValid_AM0, iData_AM0, iValid_AM1, iData_AM1, iReady_BM,
      input  oReady_AM0, oReady_AM1, oValid_BM, oData_BM
   );
endinterface

`default_nettype wire

// File: rtl/registered_combiner.sv
// +--------------------------------------------------------------------------+
// | registered_combiner : pairs one word from each lane into {lane0, lane1}.  |
// | Option macro: REGISTERED_COMBINER_OUTREG_EN (extra output skid stage).    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module registered_combiner_lane #(
   parameter int          WIDTH = 4,
   parameter logic [23:0] BURST = "yes"
) (
   input  wire logic             iCLK,
   input  wire logic             iRST,
   input  wire logic             i_valid,
   output logic                  o_ready,
   input  wire logic [WIDTH-1:0] i_data,
   output logic                  o_valid,
   output logic [WIDTH-1:0]      o_data,
   input  wire logic             i_pop
);
   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic             r_ready;
   logic             w_push;

   assign w_push  = i_valid & r_ready;
   assign o_ready = r_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   generate
      if (BURST == "yes") begin : g_skid
         logic             r_svalid;
         logic [WIDTH-1:0] r_sdata;

         // Ready tracks only the skid slot, so it never depends on the pop.
         always_ff @(posedge iCLK or negedge iRST) begin
            if (!iRST) begin
               r_valid  <= 1'b0;
               r_data   <= '0;
               r_svalid <= 1'b0;
               r_sdata  <= '0;
               r_ready  <= 1'b0;
            end else if (!r_valid || i_pop) begin
               r_ready <= 1'b1;
               if (r_svalid) begin
                  r_data   <= r_sdata;
                  r_valid  <= 1'b1;
                  r_svalid <= 1'b0;
               end else if (w_push) begin
                  r_data  <= i_data;
                  r_valid <= 1'b1;
               end else begin
                  r_valid <= 1'b0;
               end
            end else if (w_push) begin
               r_sdata  <= i_data;
               r_svalid <= 1'b1;
               r_ready  <= 1'b0;
            end else begin
               r_ready <= !r_svalid;
            end
         end
      end else begin : g_single
         always_ff @(posedge iCLK or negedge iRST) begin
            if (!iRST) begin
               r_valid <= 1'b0;
               r_data  <= '0;
               r_ready <= 1'b0;
            end else if (w_push) begin
               r_data  <= i_data;
               r_valid <= 1'b1;
               r_ready <= 1'b0;
            end else if (i_pop) begin
               r_valid <= 1'b0;
               r_ready <= 1'b1;
            end else begin
               r_ready <= !r_valid;
            end
         end
      end
   endgenerate
endmodule

module registered_combiner #(
   parameter int          WIDTH0 = 4,
   parameter int          WIDTH1 = 4,
   parameter logic [23:0] BURST  = "yes"
) (
   input wire logic iCLK,
   input wire logic iRST,
   registered_combiner_if.slave bus
);
   logic                     w_v0;
   logic                     w_v1;
   logic [WIDTH0-1:0]        w_d0;
   logic [WIDTH1-1:0]        w_d1;
   logic                     w_both;
   logic                     w_out_ready;
   logic                     w_pop;
   logic [WIDTH0+WIDTH1-1:0] w_word;

   assign w_both = w_v0 & w_v1;
   assign w_pop  = w_both & w_out_ready;
   assign w_word = {w_d0, w_d1};

   registered_combiner_lane #(.WIDTH(WIDTH0), .BURST(BURST)) u_lane0 (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .i_valid (bus.iValid_AM0),
      .o_ready (bus.oReady_AM0),
      .i_data  (bus.iData_AM0),
      .o_valid (w_v0),
      .o_data  (w_d0),
      .i_pop   (w_pop)
   );

   registered_combiner_lane #(.WIDTH(WIDTH1), .BURST(BURST)) u_lane1 (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .i_valid (bus.iValid_AM1),
      .o_ready (bus.oReady_AM1),
      .i_data  (bus.iData_AM1),
      .o_valid (w_v1),
      .o_data  (w_d1),
      .i_pop   (w_pop)
   );

`ifdef REGISTERED_COMBINER_OUTREG_EN
   logic w_out_pop;

   assign w_out_pop = bus.oValid_BM & bus.iReady_BM;

   registered_combiner_lane #(.WIDTH(WIDTH0 + WIDTH1), .BURST("yes")) u_outreg (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .i_valid (w_both),
      .o_ready (w_out_ready),
      .i_data  (w_word),
      .o_valid (bus.oValid_BM),
      .o_data  (bus.oData_BM),
      .i_pop   (w_out_pop)
   );
`else
   assign w_out_ready  = bus.iReady_BM;
   assign bus.oValid_BM = w_both;
   assign bus.oData_BM  = w_word;
`endif
endmodule

`default_nettype wire

// File: tb/tb_registered_combiner.sv
// Directed bench for registered_combiner: one BURST="yes" and one BURST="no" instance.
`default_nettype none

module tb_registered_combiner;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   registered_combiner_if #(.WIDTH0(4), .WIDTH1(4)) ify ();
   registered_combiner_if #(.WIDTH0(4), .WIDTH1(4)) ifn ();

   registered_combiner #(.WIDTH0(4), .WIDTH1(4), .BURST("yes")) dut_y (
      .iCLK (clk),
      .iRST (rst_n),
      .bus  (ify)
   );

   registered_combiner #(.WIDTH0(4), .WIDTH1(4), .BURST("no")) dut_n (
      .iCLK (clk),
      .iRST (rst_n),
      .bus  (ifn)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] got[$];
      logic [7:0] last;
      logic [3:0] a0[16];
      logic [3:0] a1[16];
      int  pulses, firstc, lastc, lowcnt, i0, i1, k;
      bit  acc0, acc1, sawlow, pstall;
      logic [7:0] pdata;

      ify.iValid_AM0 = 0; ify.iData_AM0 = 0; ify.iValid_AM1 = 0; ify.iData_AM1 = 0;
      ify.iReady_BM  = 1;
      ifn.iValid_AM0 = 0; ifn.iData_AM0 = 0; ifn.iValid_AM1 = 0; ifn.iData_AM1 = 0;
      ifn.iReady_BM  = 1;

      // Reset state
      #12;
      chk("rst_valid", ify.oValid_BM, 0);
      chk("rst_data", ify.oData_BM, 0);
      chk("rst_ready0", ify.oReady_AM0, 0);
      chk("rst_ready1", ify.oReady_AM1, 0);
      chk("rst_valid_n", ifn.oValid_BM, 0);
      chk("rst_ready0_n", ifn.oReady_AM0, 0);
      @(negedge clk);
      rst_n = 1;
      cyc();
      chk("post_rst_ready0", ify.oReady_AM0, 1);
      chk("post_rst_ready1", ify.oReady_AM1, 1);
      chk("post_rst_ready1_n", ifn.oReady_AM1, 1);

      // Lane 0 then lane 1 on consecutive cycles -> single pulse 8'hab
      ify.iValid_AM0 = 1; ify.iData_AM0 = 4'ha;
      cyc();
      ify.iValid_AM0 = 0; ify.iValid_AM1 = 1; ify.iData_AM1 = 4'hb;
      @(negedge clk);
      chk("lone_lane_no_out", ify.oValid_BM, 0);
      cyc();
      ify.iValid_AM1 = 0;
      pulses = 0; last = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) chk("latency1_valid", ify.oValid_BM, 1);
         if (ify.oValid_BM) begin
            pulses++;
            last = ify.oData_BM;
         end
      end
      chk("ab_pulses", pulses, 1);
      chk("ab_data", last, 8'hab);
      chk("ab_ready0", ify.oReady_AM0, 1);
      chk("ab_ready1", ify.oReady_AM1, 1);

      // Stall: 7 waits three cycles for 8, output held while iReady_BM=0
      cyc();
      ify.iReady_BM = 0;
      ify.iValid_AM0 = 1; ify.iData_AM0 = 4'h7;
      cyc();
      ify.iValid_AM0 = 0;
      cyc(); cyc(); cyc();
      ify.iValid_AM1 = 1; ify.iData_AM1 = 4'h8;
      cyc();
      ify.iValid_AM1 = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid", ify.oValid_BM, 1);
         chk("stall_data", ify.oData_BM, 8'h78);
         cyc();
      end
      ify.iReady_BM = 1;
      @(negedge clk);
      chk("release_valid", ify.oValid_BM, 1);
      chk("release_data", ify.oData_BM, 8'h78);
      cyc();
      @(negedge clk);
      chk("consumed_once", ify.oValid_BM, 0);
      chk("stall_ready0", ify.oReady_AM0, 1);
      chk("stall_ready1", ify.oReady_AM1, 1);

      // BURST="yes" full-rate stream 1..8
      cyc();
      got.delete(); firstc = -1; lastc = -1; lowcnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (i < 8) begin
            ify.iValid_AM0 = 1; ify.iData_AM0 = 4'(i + 1);
            ify.iValid_AM1 = 1; ify.iData_AM1 = 4'(i + 1);
         end else begin
            ify.iValid_AM0 = 0; ify.iValid_AM1 = 0;
         end
         @(negedge clk);
         if (i < 8 && !(ify.oReady_AM0 && ify.oReady_AM1)) lowcnt++;
         if (ify.oValid_BM && ify.iReady_BM) begin
            got.push_back(ify.oData_BM);
            if (firstc < 0) firstc = i;
            lastc = i;
         end
         cyc();
      end
      chk("burst_count", got.size(), 8);
      chk("burst_span", lastc - firstc, 7);
      chk("burst_ready_low", lowcnt, 0);
      for (int j = 0; j < got.size(); j++) chk("burst_word", got[j], {4'(j + 1), 4'(j + 1)});

      // BURST="no" same stream with proper handshaking
      got.delete(); i0 = 0; i1 = 0; sawlow = 0;
      for (int c = 0; c < 80 && got.size() < 8; c++) begin
         ifn.iValid_AM0 = (i0 < 8); ifn.iData_AM0 = 4'(i0 + 1);
         ifn.iValid_AM1 = (i1 < 8); ifn.iData_AM1 = 4'(i1 + 1);
         @(negedge clk);
         acc0 = ifn.iValid_AM0 && ifn.oReady_AM0;
         acc1 = ifn.iValid_AM1 && ifn.oReady_AM1;
         if (!ifn.oReady_AM0 || !ifn.oReady_AM1) sawlow = 1;
         if (ifn.oValid_BM && ifn.iReady_BM) got.push_back(ifn.oData_BM);
         cyc();
         if (acc0) i0++;
         if (acc1) i1++;
      end
      ifn.iValid_AM0 = 0; ifn.iValid_AM1 = 0;
      chk("single_count", got.size(), 8);
      chk("single_ready_toggle", sawlow, 1);
      for (int j = 0; j < got.size(); j++) chk("single_word", got[j], {4'(j + 1), 4'(j + 1)});

      // Reset while lane 0 holds a word
      ify.iReady_BM = 0;
      ify.iValid_AM0 = 1; ify.iData_AM0 = 4'h5;
      cyc();
      ify.iValid_AM0 = 0;
      cyc();
      #2 rst_n = 0;
      #1;
      chk("midrst_valid", ify.oValid_BM, 0);
      chk("midrst_data", ify.oData_BM, 0);
      chk("midrst_ready0", ify.oReady_AM0, 0);
      chk("midrst_ready1", ify.oReady_AM1, 0);
      @(negedge clk);
      rst_n = 1;
      cyc();
      ify.iReady_BM = 1;
      ify.iValid_AM1 = 1; ify.iData_AM1 = 4'h6;
      cyc();
      ify.iValid_AM1 = 0;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ify.oValid_BM) pulses++;
      end
      chk("no_stale_word", pulses, 0);
      cyc();
      ify.iValid_AM0 = 1; ify.iData_AM0 = 4'h9;
      cyc();
      ify.iValid_AM0 = 0;
      @(negedge clk);
      chk("post_rst_pair_valid", ify.oValid_BM, 1);
      chk("post_rst_pair_data", ify.oData_BM, 8'h96);
      cyc();

      // Random valid/ready against in-order pairing model
      for (int j = 0; j < 16; j++) begin
         a0[j] = 4'($urandom_range(0, 15));
         a1[j] = 4'($urandom_range(0, 15));
      end
      i0 = 0; i1 = 0; k = 0; acc0 = 0; acc1 = 0; pstall = 0; pdata = 0;
      for (int c = 0; c < 1000 && k < 16; c++) begin
         if (acc0) i0++;
         if (acc1) i1++;
         if (!(ify.iValid_AM0 && !acc0)) ify.iValid_AM0 = (i0 < 16) && ($urandom_range(0, 3) != 0);
         if (!(ify.iValid_AM1 && !acc1)) ify.iValid_AM1 = (i1 < 16) && ($urandom_range(0, 3) != 0);
         ify.iData_AM0 = a0[(i0 < 16) ? i0 : 15];
         ify.iData_AM1 = a1[(i1 < 16) ? i1 : 15];
         ify.iReady_BM = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         acc0 = ify.iValid_AM0 && ify.oReady_AM0;
         acc1 = ify.iValid_AM1 && ify.oReady_AM1;
         if (pstall) chk("rand_hold", {ify.oValid_BM, ify.oData_BM}, {1'b1, pdata});
         pstall = ify.oValid_BM && !ify.iReady_BM;
         pdata  = ify.oData_BM;
         if (ify.oValid_BM && ify.iReady_BM) begin
            if (k < 16) chk("rand_pair", ify.oData_BM, {a0[k], a1[k]});
            k++;
         end
         cyc();
      end
      ify.iValid_AM0 = 0; ify.iValid_AM1 = 0; ify.iReady_BM = 1;
      chk("rand_count", k, 16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
